loop_sequencer: RTL and testbench
=================================

# loop_sequencer

Control-loop sequencer for the accelerator's shared datapath. A programmable sample timer triggers a fixed sequence each period:
- latch the ADC sample;
- issue it to the CORDIC magnitude unit and wait its fixed latency;
- feed the magnitude to the PID unit as the feedback value and wait its latency;
- publish the PID output with a one-cycle valid strobe.

It sits above the timing unit and is the only source of the CORDIC and PID write enables.

## Interface
- `DW`, 12, sample / CORDIC data width
- `UW`, 17, PID output width
- `PW`, 16, period counter width
- `CORDIC_LAT`, 16, cycles from CORDIC write to valid `cordic_mag` (≥1)
- `PID_LAT`, 3, cycles from PID write to valid `pid_uk` (≥1)

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `en` in 1: enables the sample timer.
- `period` in PW: sample period in cycles; 0 stops the timer.
- `adc_data` in DW: sample, captured on the tick cycle.
- `cordic_we` out 1: write strobe to the CORDIC unit.
- `cordic_data` out DW: CORDIC input operand.
- `cordic_mag` in DW: CORDIC result.
- `pid_we` out 1: write strobe to the PID unit.
- `pid_y` out DW: PID feedback operand.
- `pid_uk` in UW: PID result.
- `u_out` out UW: last PID result.
- `u_valid` out 1: one-cycle strobe marking a new `u_out`.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky; a tick was dropped.
- `clear_ovr` in 1: clears `overrun`.

## Operation
- **Timer:** `cnt` increments while `en=1` and `period≠0`.
  - Tick is combinational, when `cnt >= period-1`; `cnt` wraps to 0 on the same edge.
  - `en=0` or `period=0` holds `cnt` at 0 and produces no tick.
  - Because the compare uses `>=`, shrinking `period` below the current `cnt` fires a tick on the next cycle. No wrap glitch occurs.
- **FSM states:** IDLE, C_ISSUE, C_WAIT, P_ISSUE, P_WAIT, DONE.
  - IDLE or DONE, tick → C_ISSUE. `adc_data` is latched into `cordic_data` on that edge.
  - DONE without tick → IDLE.
  - C_ISSUE: `cordic_we=1` for exactly 1 cycle → C_WAIT. The wait counter is loaded with `CORDIC_LAT-1`.
  - C_WAIT: decrement the counter. At 0, capture `cordic_mag` into `pid_y` → P_ISSUE.
  - P_ISSUE: `pid_we=1` for 1 cycle → P_WAIT. The counter is loaded with `PID_LAT-1`.
  - P_WAIT: decrement. At 0, capture `pid_uk` into `u_out` → DONE.
  - DONE: `u_valid=1` for 1 cycle.
- **Overrun:** a tick in C_ISSUE, C_WAIT, P_ISSUE or P_WAIT is dropped and `overrun` is set.
  - The running sequence is unaffected.
  - If `clear_ovr` and a dropped tick occur in the same cycle, set wins.
- **`en` deasserted mid-sequence:** the sequence completes normally; no new tick follows.
- **Operands:** `cordic_data` and `pid_y` are held stable between issues. The CORDIC and PID units sample them on their `we`.
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Reset values:
  - `cordic_we`, `pid_we`, `u_valid`, `busy`, `overrun` = 0.
  - `cordic_data`, `pid_y` = 0; `u_out` = 0.
  - FSM = IDLE; `cnt` = 0.
- Tick on cycle T:
  - `cordic_we` at T+1.
  - `cordic_mag` sampled at the end of T+1+CORDIC_LAT.
  - `pid_we` at T+2+CORDIC_LAT.
  - `pid_uk` sampled at the end of T+2+CORDIC_LAT+PID_LAT.
  - `u_valid` and new `u_out` at T+3+CORDIC_LAT+PID_LAT. With defaults, this is T+22.
- Minimum period without overrun = CORDIC_LAT+PID_LAT+3 (22 with defaults). A tick arriving in DONE is accepted.
- `busy` is registered with the state and is high from T+1 through the DONE cycle.
- Reset asserted mid-sequence: all state clears immediately. A partial result is never published.

## Structure
- Package `loop_seq_pkg`:
  - state enum;
  - default latency constants `CORDIC_LAT_DEF=16`, `PID_LAT_DEF=3`;
  - a derived `MIN_PERIOD` function.
- Sub-module `sample_timer`: owns the period counter and produces the tick. Inputs are `en` and `period`.
- The FSM, wait counter (width `$clog2(max(CORDIC_LAT,PID_LAT))+1`), operand registers and overrun flag live in the top level.

## Test plan
- **Basic sequence:** defaults, `period=30`, `en=1`, `adc_data=0x123`, CORDIC model returns `0x0A5` after 16 cycles, PID model returns `0x1F00F` after 3 cycles.
  - `cordic_we` 1 cycle after tick with `cordic_data=0x123`.
  - `pid_we` with `pid_y=0x0A5`.
  - `u_valid` 22 cycles after tick with `u_out=0x1F00F`.
  - Repeats every 30 cycles.
- **Back-to-back at minimum period:** `period=22`.
  - A tick lands in DONE and is accepted.
  - `u_valid` every 22 cycles; `overrun` stays 0.
- **Overrun:** `period=10`.
  - The first sequence completes.
  - Ticks at +10 and +20 are dropped and `overrun` goes to 1.
  - `clear_ovr` pulsed in a cycle with a dropped tick → `overrun` stays 1.
  - `clear_ovr` pulsed in a non-tick cycle → `overrun` goes to 0.
- **Disable mid-sequence:** deassert `en` at T+5.
  - `u_valid` still at T+22.
  - No further `cordic_we`.
  - `cnt` holds 0.
- **Period zero / change:**
  - `period=0` → no tick for 100 cycles.
  - Set `period=50` → first tick 50 cycles later.
  - Drop `period` from 50 to 5 while `cnt=20` → tick next cycle.
- **Async reset mid-sequence:** pull `rstn` low at T+10 → all outputs 0 immediately, no `u_valid`.

Source files
------------

// File: rtl/loop_seq_pkg.sv
// Shared types and constants for the control-loop sequencer.
package loop_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    C_ISSUE,
    C_WAIT,
    P_ISSUE,
    P_WAIT,
    DONE
  } seq_state_t;

  localparam int unsigned CORDIC_LAT_DEF = 16;
  localparam int unsigned PID_LAT_DEF    = 3;

  // Shortest sample period that never lands a tick inside a running sequence.
  function automatic int unsigned MIN_PERIOD(input int unsigned cordic_lat,
                                             input int unsigned pid_lat);
    return cordic_lat + pid_lat + 3;
  endfunction

  function automatic int unsigned wait_width(input int unsigned cordic_lat,
                                             input int unsigned pid_lat);
    return $clog2((cordic_lat > pid_lat) ? cordic_lat : pid_lat) + 1;
  endfunction

endpackage

// File: rtl/sample_timer.sv
// Programmable sample timer: free-running period counter with a combinational tick.
module sample_timer #(
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [PW-1:0] period,
  output logic          tick
);

  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] cnt;
  logic          run;

  assign run = en && (period != '0);
  // The >= compare lets a shrinking period fire at once instead of waiting for a wrap.
  assign tick = run && (cnt >= (period - ONE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Control-loop sequencer: per sample tick, run ADC -> CORDIC -> PID and publish the result.
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int unsigned DW         = 12,
  parameter int unsigned UW         = 17,
  parameter int unsigned PW         = 16,
  parameter int unsigned CORDIC_LAT = CORDIC_LAT_DEF,
  parameter int unsigned PID_LAT    = PID_LAT_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [PW-1:0] period,
  input  logic [DW-1:0] adc_data,
  output logic          cordic_we,
  output logic [DW-1:0] cordic_data,
  input  logic [DW-1:0] cordic_mag,
  output logic          pid_we,
  output logic [DW-1:0] pid_y,
  input  logic [UW-1:0] pid_uk,
  output logic [UW-1:0] u_out,
  output logic          u_valid,
  output logic          busy,
  output logic          overrun,
  input  logic          clear_ovr
);

  localparam int unsigned WW = wait_width(CORDIC_LAT, PID_LAT);
  localparam logic [WW-1:0] C_LOAD  = WW'(CORDIC_LAT - 1);
  localparam logic [WW-1:0] P_LOAD  = WW'(PID_LAT - 1);
  localparam logic [WW-1:0] W_ONE   = WW'(1);

  seq_state_t    state, state_nx;
  logic [WW-1:0] wcnt;
  logic          tick;
  logic          accept;
  logic          drop;

  sample_timer #(
    .PW(PW)
  ) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en),
    .period(period),
    .tick  (tick)
  );

  assign accept = tick && ((state == IDLE) || (state == DONE));
  assign drop   = tick && !((state == IDLE) || (state == DONE));

  assign cordic_we = (state == C_ISSUE);
  assign pid_we    = (state == P_ISSUE);
  assign u_valid   = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick) state_nx = C_ISSUE;
      C_ISSUE: state_nx = C_WAIT;
      C_WAIT:  if (wcnt == '0) state_nx = P_ISSUE;
      P_ISSUE: state_nx = P_WAIT;
      P_WAIT:  if (wcnt == '0) state_nx = DONE;
      DONE:    state_nx = tick ? C_ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt        <= '0;
      cordic_data <= '0;
      pid_y       <= '0;
      u_out       <= '0;
    end else begin
      if (accept) begin
        cordic_data <= adc_data;
      end
      unique case (state)
        C_ISSUE: wcnt <= C_LOAD;
        C_WAIT: begin
          if (wcnt == '0) pid_y <= cordic_mag;
          else            wcnt  <= wcnt - W_ONE;
        end
        P_ISSUE: wcnt <= P_LOAD;
        P_WAIT: begin
          if (wcnt == '0) u_out <= pid_uk;
          else            wcnt  <= wcnt - W_ONE;
        end
        default: ;
      endcase
    end
  end

  // A dropped tick outranks a simultaneous clear so no overrun is ever lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer with cycle-arithmetic reference model.
module tb_loop_sequencer;

  localparam int DW  = 12;
  localparam int UW  = 17;
  localparam int PW  = 16;
  localparam int CL  = 16;
  localparam int PL  = 3;
  localparam int SEQ = CL + PL + 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          clear_ovr = 1'b0;
  logic [PW-1:0] period = '0;
  logic [DW-1:0] adc_data = '0;
  logic          cordic_we, pid_we, u_valid, busy, overrun;
  logic [DW-1:0] cordic_data, cordic_mag, pid_y;
  logic [UW-1:0] pid_uk, u_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  loop_sequencer #(
    .DW(DW), .UW(UW), .PW(PW), .CORDIC_LAT(CL), .PID_LAT(PL)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .period(period), .adc_data(adc_data),
    .cordic_we(cordic_we), .cordic_data(cordic_data), .cordic_mag(cordic_mag),
    .pid_we(pid_we), .pid_y(pid_y), .pid_uk(pid_uk), .u_out(u_out),
    .u_valid(u_valid), .busy(busy), .overrun(overrun), .clear_ovr(clear_ovr)
  );

  // Latency-accurate CORDIC/PID stand-ins; outside the valid cycle they drive junk.
  int            c_cnt = 0, p_cnt = 0;
  logic [DW-1:0] c_lat = '0, p_lat = '0;
  always @(posedge clk) begin
    if (cordic_we) begin c_cnt <= CL; c_lat <= cordic_data; end
    else if (c_cnt > 0) c_cnt <= c_cnt - 1;
    if (pid_we) begin p_cnt <= PL; p_lat <= pid_y; end
    else if (p_cnt > 0) p_cnt <= p_cnt - 1;
  end
  assign cordic_mag = (c_cnt == 1) ? (c_lat ^ 12'h186) : 12'hBAD;
  assign pid_uk     = (p_cnt == 1) ? ({5'b0, p_lat} ^ 17'h1F0AA) : 17'h0DEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a sequence started on tick cycle ms produces each output at a fixed offset.
  int            ms = -1, mc = 0, mcnt = 0;
  bit            movr = 1'b0;
  logic [DW-1:0] m_cdata = '0, m_pidy = '0;
  logic [UW-1:0] m_u = '0;

  always @(negedge clk) begin
    bit act, tk, dropped;
    if (!rstn) begin
      ms = -1; mcnt = 0; movr = 1'b0; m_cdata = '0; m_pidy = '0; m_u = '0;
    end
    act = (ms >= 0);
    chk("cordic_we",   cordic_we,   act && (mc == ms + 1));
    chk("pid_we",      pid_we,      act && (mc == ms + 2 + CL));
    chk("u_valid",     u_valid,     act && (mc == ms + SEQ));
    chk("busy",        busy,        act && (mc >= ms + 1) && (mc <= ms + SEQ));
    chk("overrun",     overrun,     movr);
    chk("cordic_data", cordic_data, m_cdata);
    chk("pid_y",       pid_y,       m_pidy);
    chk("u_out",       u_out,       m_u);
    chk("timer_cnt",   dut.u_timer.cnt, mcnt);
    if (rstn) begin
      if (act && mc == ms + 1 + CL)      m_pidy = m_cdata ^ 12'h186;
      if (act && mc == ms + 2 + CL + PL) m_u = {5'b0, m_pidy} ^ 17'h1F0AA;
      tk = en && (period != 0) && (mcnt >= int'(period) - 1);
      dropped = 1'b0;
      if (tk) begin
        if (!act || mc >= ms + SEQ) begin ms = mc; m_cdata = adc_data; end
        else dropped = 1'b1;
      end
      if (dropped) movr = 1'b1;
      else if (clear_ovr) movr = 1'b0;
      if (!en || period == 0 || tk) mcnt = 0;
      else mcnt++;
    end
    mc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel: 0 cordic_we, 1 pid_we, 2 u_valid, 3 not busy
  task automatic wait_for(input int sel, input int maxc, output bit found, output int when);
    found = 1'b0;
    when = -1;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if ((sel == 0 && cordic_we) || (sel == 1 && pid_we) ||
          (sel == 2 && u_valid) || (sel == 3 && !busy)) begin
        found = 1'b1;
        when = cyc;
      end
    end
  endtask

  task automatic go_idle();
    bit f;
    int t;
    en = 1'b0;
    wait_for(3, 40, f, t);
    chk("idle_reached", f, 1);
    step(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cwe"},   cordic_we,   0);
    chk({tag, "_pwe"},   pid_we,      0);
    chk({tag, "_uv"},    u_valid,     0);
    chk({tag, "_busy"},  busy,        0);
    chk({tag, "_ovr"},   overrun,     0);
    chk({tag, "_cdata"}, cordic_data, 0);
    chk({tag, "_pidy"},  pid_y,       0);
    chk({tag, "_uout"},  u_out,       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit f;
    int t0, t1, t2, t3, ten;

    step(3);
    chk_all_zero("reset");
    rstn = 1'b1;
    step(2);

    // Basic sequence
    adc_data = 12'h123; period = 30; en = 1'b1; ten = cyc;
    wait_for(0, 40, f, t0);
    chk("basic_cwe_seen", f, 1);
    chk("basic_first_tick", t0 - ten, 30);
    chk("basic_cdata", cordic_data, 12'h123);
    wait_for(1, 30, f, t1);
    chk("basic_pwe_lat", t1 - t0, 17);
    chk("basic_pid_y", pid_y, 12'h0A5);
    wait_for(2, 30, f, t2);
    chk("basic_uv_lat", t2 - t0, 21);
    chk("basic_u_out", u_out, 17'h1F00F);
    wait_for(0, 30, f, t3);
    chk("basic_repeat", t3 - t0, 30);
    go_idle();

    // Back-to-back at minimum period
    period = 22; en = 1'b1;
    wait_for(2, 60, f, t0);
    chk("b2b_uv_seen", f, 1);
    wait_for(0, 3, f, t1);
    chk("b2b_accept_in_done", t1 - t0, 1);
    wait_for(2, 30, f, t2);
    chk("b2b_uv_period1", t2 - t0, 22);
    wait_for(2, 30, f, t3);
    chk("b2b_uv_period2", t3 - t2, 22);
    chk("b2b_no_overrun", overrun, 0);
    go_idle();

    // Overrun: t0 is T+1
    period = 10; en = 1'b1;
    wait_for(0, 20, f, t0);
    chk("ovr_cwe_seen", f, 1);
    step(10);
    chk("ovr_set", overrun, 1);
    step(9);
    clear_ovr = 1'b1;
    step(1);
    clear_ovr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    wait_for(2, 5, f, t1);
    chk("ovr_first_done", t1 - t0, 21);
    chk("ovr_u_out", u_out, 17'h1F00F);
    step(3);
    clear_ovr = 1'b1;
    step(1);
    clear_ovr = 1'b0;
    chk("ovr_clear", overrun, 0);
    go_idle();

    // Disable mid-sequence at T+5
    period = 30; en = 1'b1;
    wait_for(0, 40, f, t0);
    step(4);
    en = 1'b0;
    wait_for(2, 30, f, t1);
    chk("dis_uv_lat", t1 - t0, 21);
    wait_for(0, 60, f, t2);
    chk("dis_no_cwe", f, 0);
    chk("dis_cnt_zero", dut.u_timer.cnt, 0);

    // Period zero, then 50
    period = 0; en = 1'b1;
    wait_for(0, 100, f, t0);
    chk("p0_no_tick", f, 0);
    period = 50; ten = cyc;
    wait_for(0, 60, f, t0);
    chk("p50_first", t0 - ten, 50);
    go_idle();

    // Shrink period below the running count: tick in the first cycle 5 is visible
    period = 50; en = 1'b1; ten = cyc;
    step(20);
    chk("chg_cnt20", dut.u_timer.cnt, 20);
    period = 5;
    wait_for(0, 3, f, t0);
    chk("chg_tick", t0 - ten, 21);
    go_idle();
    clear_ovr = 1'b1;
    step(1);
    clear_ovr = 1'b0;

    // Async reset at T+10
    period = 30; en = 1'b1;
    wait_for(0, 40, f, t0);
    step(9);
    rstn = 1'b0;
    #1;
    chk_all_zero("arst");
    en = 1'b0;
    step(2);
    rstn = 1'b1;
    wait_for(2, 30, f, t1);
    chk("arst_no_uvalid", f, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
